// File: rtl/muldiv_hilo_pkg.sv
// Shared opcodes, FSM encoding and decode helpers for the multiply/divide unit.
package muldiv_hilo_pkg;

    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_DIV_RUN = 1'b1
    } state_t;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/muldiv_hilo_div_radix2.sv
// Radix-2 restoring divider: one quotient bit per cycle, sign fix applied on the final step.
module div_radix2
    import muldiv_hilo_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done_c,
    output logic [WIDTH-1:0] quot_c,
    output logic [WIDTH-1:0] rem_c
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [CW-1:0]    count_q;
    logic             negq_q;
    logic             negr_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quot_nxt;

    // Operand magnitudes; unsigned divides pass straight through.
    always_comb begin
        a_mag = (signed_op && a[WIDTH-1]) ? -a : a;
        b_mag = (signed_op && b[WIDTH-1]) ? -b : b;
    end

    // One restoring step; the shifted remainder needs an extra bit for large divisors.
    always_comb begin
        rem_sh    = {rem_q, quot_q[WIDTH-1]};
        diff      = {1'b0, rem_sh} - {2'b00, dvsr_q};
        no_borrow = ~diff[WIDTH+1];
        rem_nxt   = no_borrow ? WIDTH'(diff) : WIDTH'(rem_sh);
        quot_nxt  = {quot_q[WIDTH-2:0], no_borrow};
        done_c    = busy && (count_q == CW'(WIDTH - 1));
        quot_c    = negq_q ? -quot_nxt : quot_nxt;
        rem_c     = negr_q ? -rem_nxt : rem_nxt;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy    <= 1'b0;
            count_q <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            dvsr_q  <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else if (abort) begin
            busy    <= 1'b0;
            count_q <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            count_q <= '0;
            rem_q   <= '0;
            quot_q  <= a_mag;
            dvsr_q  <= b_mag;
            negq_q  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            negr_q  <= signed_op & a[WIDTH-1];
        end else if (busy) begin
            rem_q  <= rem_nxt;
            quot_q <= quot_nxt;
            if (done_c) begin
                busy    <= 1'b0;
                count_q <= '0;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/muldiv_hilo.sv
// EX-stage multiply/divide unit owning HI/LO, op decode and the divide stall.
module muldiv_hilo
    import muldiv_hilo_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [7:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned PW = 2 * WIDTH;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             div_op;
    logic             div_zero;
    logic             div_accept;
    logic [PW-1:0]    prod_s;
    logic [PW-1:0]    prod_u;
    logic             div_busy;
    logic             div_done_c;
    logic [WIDTH-1:0] div_quot_c;
    logic [WIDTH-1:0] div_rem_c;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;
    logic             done_nxt;

    // Decode: flush always wins over a new op.
    always_comb begin
        accept     = (state == ST_IDLE) && start && !flush;
        div_op     = is_div_op(alucontrol);
        div_zero   = (b == '0);
        div_accept = accept && div_op && !div_zero;
    end

    always_comb begin
        prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    end

    div_radix2 #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_accept),
        .abort     (flush),
        .signed_op (alucontrol == EXE_DIV_OP),
        .a         (a),
        .b         (b),
        .busy      (div_busy),
        .done_c    (div_done_c),
        .quot_c    (div_quot_c),
        .rem_c     (div_rem_c)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (div_accept) begin
                    state_nxt = ST_DIV_RUN;
                end
            end
            ST_DIV_RUN: begin
                if (flush || div_done_c || !div_busy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stall and next HI/LO/done values; a flush cancels any pending write.
    always_comb begin
        stall    = ((state == ST_DIV_RUN) || div_accept) && !flush;
        hi_nxt   = hi;
        lo_nxt   = lo;
        done_nxt = 1'b0;
        if (accept) begin
            case (alucontrol)
                EXE_MULT_OP:  {hi_nxt, lo_nxt} = prod_s;
                EXE_MULTU_OP: {hi_nxt, lo_nxt} = prod_u;
                EXE_MTHI_OP:  hi_nxt = a;
                EXE_MTLO_OP:  lo_nxt = a;
                EXE_DIV_OP,
                EXE_DIVU_OP:  done_nxt = div_zero;
                default:      ;
            endcase
        end
        if ((state == ST_DIV_RUN) && div_done_c && !flush) begin
            hi_nxt   = div_rem_c;
            lo_nxt   = div_quot_c;
            done_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            hi   <= hi_nxt;
            lo   <= lo_nxt;
            done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed and randomized checks of muldiv_hilo against an arithmetic HI/LO model.
module tb_muldiv_hilo;
    import muldiv_hilo_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [7:0]   alucontrol;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         stall;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    always #5 clk = ~clk;

    muldiv_hilo #(.WIDTH(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .flush      (flush),
        .stall      (stall),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start      = 1'b0;
        flush      = 1'b0;
        alucontrol = 8'h00;
        a          = '0;
        b          = '0;
    endtask

    function automatic logic div_kind(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

    // Architectural effect of a retired op on HI/LO, in plain integer arithmetic.
    task automatic model(input logic [7:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (op)
            EXE_MULT_OP:  {m_hi, m_lo} = 64'(sx * sy);
            EXE_MULTU_OP: {m_hi, m_lo} = 64'(ux * uy);
            EXE_MTHI_OP:  m_hi = x;
            EXE_MTLO_OP:  m_lo = x;
            EXE_DIV_OP: if (y != '0) begin
                m_lo = W'(sx / sy);
                m_hi = W'(sx % sy);
            end
            EXE_DIVU_OP: if (y != '0) begin
                m_lo = x / y;
                m_hi = x % y;
            end
            default: ;
        endcase
    endtask

    // Issue one op in cycle T; optional flush or reset at cycle T+n of a divide.
    task automatic run_op(input logic [7:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int flush_at, input int reset_at);
        logic long_div;
        long_div   = div_kind(op) && (y != '0);
        start      = 1'b1;
        alucontrol = op;
        a          = x;
        b          = y;
        flush      = 1'b0;
        #1;
        check1("stall_accept", stall, long_div);
        tick();
        if (!long_div) begin
            model(op, x, y);
            idle_inputs();
            #1;
            check1("done_short", done, div_kind(op));
            check1("stall_short", stall, 1'b0);
            check32("hi_short", hi, m_hi);
            check32("lo_short", lo, m_lo);
            return;
        end
        for (int c = 1; c <= int'(W); c++) begin
            start      = ($urandom_range(0, 1) == 1);
            alucontrol = EXE_MTHI_OP;
            a          = $urandom;
            b          = $urandom;
            if (c == flush_at) begin
                flush = 1'b1;
                #1;
                check1("stall_flush", stall, 1'b0);
                tick();
                idle_inputs();
                #1;
                check1("done_flush", done, 1'b0);
                check1("stall_after_flush", stall, 1'b0);
                check32("hi_flush", hi, m_hi);
                check32("lo_flush", lo, m_lo);
                return;
            end
            if (c == reset_at) begin
                resetn = 1'b0;
                tick();
                resetn = 1'b1;
                idle_inputs();
                m_hi = '0;
                m_lo = '0;
                #1;
                check1("done_reset", done, 1'b0);
                check1("stall_reset", stall, 1'b0);
                check32("hi_reset", hi, m_hi);
                check32("lo_reset", lo, m_lo);
                return;
            end
            #1;
            check1("stall_run", stall, 1'b1);
            check1("done_run", done, 1'b0);
            check32("hi_run", hi, m_hi);
            tick();
        end
        idle_inputs();
        model(op, x, y);
        #1;
        check1("done_div", done, 1'b1);
        check1("stall_div_end", stall, 1'b0);
        check32("hi_div", hi, m_hi);
        check32("lo_div", lo, m_lo);
        tick();
        check1("done_div_pulse", done, 1'b0);
    endtask

    function automatic logic [W-1:0] rnd_word();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [7:0] ops [7];
        ops = '{EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP,
                EXE_MTHI_OP, EXE_MTLO_OP, 8'h25};

        idle_inputs();
        resetn = 1'b0;
        m_hi   = '0;
        m_lo   = '0;
        tick();
        tick();
        check32("reset_hi", hi, 32'h0);
        check32("reset_lo", lo, 32'h0);
        check1("reset_done", done, 1'b0);
        check1("reset_stall", stall, 1'b0);
        resetn = 1'b1;
        tick();

        run_op(EXE_MULT_OP,  32'hFFFF_FFFF, 32'd2, 0, 0);
        check32("mult_hi_const", hi, 32'hFFFF_FFFF);
        check32("mult_lo_const", lo, 32'hFFFF_FFFE);
        run_op(EXE_MULTU_OP, 32'hFFFF_FFFF, 32'd2, 0, 0);
        check32("multu_hi_const", hi, 32'h0000_0001);

        run_op(EXE_DIVU_OP, 32'd100, 32'd7, 0, 0);
        check32("divu_lo_const", lo, 32'd14);
        check32("divu_hi_const", hi, 32'd2);
        run_op(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check32("div_neg_lo", lo, 32'hFFFF_FFFD);
        check32("div_neg_hi", hi, 32'hFFFF_FFFF);
        run_op(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check32("div_ovf_lo", lo, 32'h8000_0000);
        check32("div_ovf_hi", hi, 32'h0);

        run_op(EXE_MTHI_OP, 32'h1234, 32'h0, 0, 0);
        run_op(EXE_MTLO_OP, 32'h5678, 32'h0, 0, 0);
        run_op(EXE_DIV_OP, 32'd5, 32'd0, 0, 0);
        check32("divz_hi", hi, 32'h1234);
        check32("divz_lo", lo, 32'h5678);
        tick();
        check1("divz_done_pulse", done, 1'b0);

        run_op(EXE_DIVU_OP, 32'd100, 32'd7, 10, 0);
        run_op(EXE_MTLO_OP, 32'hABCD, 32'h0, 0, 0);
        check32("mtlo_after_flush", lo, 32'hABCD);

        start      = 1'b1;
        flush      = 1'b1;
        alucontrol = EXE_MTHI_OP;
        a          = 32'hDEAD_BEEF;
        #1;
        check1("start_flush_stall", stall, 1'b0);
        tick();
        idle_inputs();
        #1;
        check32("start_flush_hi", hi, m_hi);

        run_op(EXE_DIVU_OP, 32'd100, 32'd7, 0, 5);
        run_op(EXE_MULT_OP, 32'd3, 32'hFFFF_FFFB, 0, 0);

        for (int i = 0; i < 24; i++) begin
            run_op(ops[$urandom_range(0, 6)], rnd_word(), rnd_word(), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
